// File: rtl/wb_uart_tx_if.sv
// Wishbone B4 pipelined bus bundle shared by the UART transmitter and its master.
interface if_wb;
   logic        clk;
   logic        rst;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [15:0] adr;
   logic [15:0] s_dat_i;
   logic [15:0] s_dat_o;
   logic        ack;
   logic        stall;

   modport slave (
      input  clk, rst, cyc, stb, we, adr, s_dat_i,
      output s_dat_o, ack, stall
   );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone slave that queues bytes in a small FIFO and shifts them out as 8N1 serial frames.
module wb_uart_tx #(
   parameter int unsigned DIV_RESET  = 434,
   parameter int unsigned FIFO_DEPTH = 8
) (
   if_wb.slave  wb,
   output logic txd
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [15:0]      divisor_q, divisor_d, div_q, div_d, baud_q, baud_d;
   logic [15:0]      dat_q, dat_d, rdata, div_eff;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_q, bit_d;
   logic             txd_q, txd_d, ack_q, ack_d;
   logic             full, empty, accept, push, pop, bit_end;

   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign wb.stall = wb.cyc & wb.stb & wb.we & (wb.adr[1:0] == 2'd0) & full;
   assign accept   = wb.cyc & wb.stb & ~wb.stall;
   assign push     = accept & wb.we & (wb.adr[1:0] == 2'd0);
   assign div_eff  = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
   assign bit_end  = (baud_q == div_q - 16'd1);

   assign wb.ack     = ack_q;
   assign wb.s_dat_o = dat_q;
   assign txd        = txd_q;

   // Register file and response path
   always_comb begin
      rdata = '0;
      case (wb.adr[1:0])
         2'd1: begin
            rdata[0]   = (state_q != IDLE) | ~empty;
            rdata[1]   = full;
            rdata[2]   = empty;
            rdata[6:3] = 4'(count_q);
         end
         2'd2:    rdata = divisor_q;
         default: rdata = '0;
      endcase
      ack_d     = accept;
      dat_d     = (accept & ~wb.we) ? rdata : 16'd0;
      divisor_d = divisor_q;
      if (accept & wb.we & (wb.adr[1:0] == 2'd2)) divisor_d = wb.s_dat_i;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty) state_d = START;
         START:   if (bit_end) state_d = DATA;
         DATA:    if (bit_end && bit_q == 3'd7) state_d = STOP;
         STOP:    if (bit_end) state_d = empty ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and outputs; txd_d follows state_d so the pin flop mirrors state_q
   always_comb begin
      pop     = ((state_q == IDLE) & ~empty) | ((state_q == STOP) & bit_end & ~empty);
      shift_d = shift_q;
      div_d   = div_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
         div_d   = div_eff;
         baud_d  = '0;
         bit_d   = '0;
      end else if (state_q != IDLE) begin
         if (bit_end) begin
            baud_d = '0;
            if (state_q == DATA) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
            end
         end else begin
            baud_d = baud_q + 16'd1;
         end
      end
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge wb.clk) begin
      if (wb.rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         divisor_q <= 16'(DIV_RESET);
         div_q     <= 16'd1;
         baud_q    <= '0;
         shift_q   <= '0;
         bit_q     <= '0;
         txd_q     <= 1'b1;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         divisor_q <= divisor_d;
         div_q     <= div_d;
         baud_q    <= baud_d;
         shift_q   <= shift_d;
         bit_q     <= bit_d;
         txd_q     <= txd_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   end

   always_ff @(posedge wb.clk) begin
      if (push) mem_q[wr_ptr_q] <= wb.s_dat_i[7:0];
   end
endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: bus accesses, frame decoding from a sampled txd trace, stall and reset behaviour.
module tb_wb_uart_tx;
   if_wb wb ();
   logic txd;

   wb_uart_tx #(.DIV_RESET(434), .FIFO_DEPTH(8)) dut (.wb(wb), .txd(txd));

   initial wb.clk = 1'b0;
   always #5 wb.clk = ~wb.clk;

   int         n_chk  = 0;
   int         n_fail = 0;
   int         n_acks = 0;
   logic       txq [$];
   logic [7:0] expq [$];
   int         divq [$];

   always @(negedge wb.clk) txq.push_back(txd);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge wb.clk); #1; end
   endtask

   task automatic wb_idle();
      wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = '0; wb.s_dat_i = '0;
   endtask

   // Present a request and hold it until accepted; returns just after the accepting edge.
   task automatic wb_req(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                         output logic [15:0] rd, output int stalls);
      logic acc;
      acc = 1'b0; stalls = 0;
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = adr; wb.s_dat_i = dat;
      for (int i = 0; i < 2000; i++) begin
         #2;
         acc = ~wb.stall;
         @(posedge wb.clk); #1;
         if (acc) break;
         stalls++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      rd = wb.s_dat_o;
      if (wb.ack === 1'b1) n_acks++;
      check("ack", {31'd0, wb.ack}, 32'd1);
   endtask

   task automatic wr(input logic [15:0] adr, input logic [15:0] dat);
      logic [15:0] rd; int st;
      wb_req(1'b1, adr, dat, rd, st);
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] adr, input logic [15:0] exp);
      logic [15:0] rd; int st;
      wb_req(1'b0, adr, 16'd0, rd, st);
      wb_idle();
      check(tag, {16'd0, rd}, {16'd0, exp});
   endtask

   // Decode the trace against expq/divq: start-bit latency, contiguous frames, idle after.
   task automatic analyse(input string tag);
      int idx, errs, base, d, b;
      logic e;
      idx = -1; errs = 0;
      for (int i = 0; i < txq.size(); i++) if (txq[i] === 1'b0) begin idx = i; break; end
      check({tag, "_lat"}, idx, 32'd1);
      base = (idx < 0) ? 0 : idx;
      for (int f = 0; f < expq.size(); f++) begin
         d = divq[f];
         for (int k = 0; k < 10 * d; k++) begin
            b = k / d;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : expq[f][b-1];
            if (base + k >= txq.size() || txq[base+k] !== e) errs++;
         end
         base += 10 * d;
      end
      for (int k = 0; k < 4; k++) if (base + k >= txq.size() || txq[base+k] !== 1'b1) errs++;
      check({tag, "_frames"}, errs, 32'd0);
      expq.delete(); divq.delete();
   endtask

   initial begin
      int st, sum_st, acks0, zeros;
      logic [15:0] rd;
      wb_idle();
      wb.rst = 1'b1;
      tick(3);
      check("rst_ack", {31'd0, wb.ack}, 32'd0);
      check("rst_dat", {16'd0, wb.s_dat_o}, 32'd0);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_stall", {31'd0, wb.stall}, 32'd0);
      wb.rst = 1'b0;
      tick(1);

      // Reset register state
      rd_chk("status_reset", 16'd1, 16'h0004);
      tick(1);
      check("ack_drop", {31'd0, wb.ack}, 32'd0);
      rd_chk("div_reset", 16'd2, 16'd434);
      rd_chk("data_read", 16'd0, 16'd0);
      rd_chk("rsvd_read", 16'd3, 16'd0);
      wb.stb = 1'b1; wb.adr = 16'd1;
      tick(1);
      check("nocyc_ack", {31'd0, wb.ack}, 32'd0);
      wb_idle();

      // Single frame 0xA5 at divisor 4
      wr(16'd2, 16'd4);
      wr(16'd1, 16'hFFFF);
      wr(16'd3, 16'hFFFF);
      wb_idle();
      rd_chk("div_wr", 16'd2, 16'd4);
      wr(16'd0, 16'h00A5);
      txq.delete(); wb_idle();
      expq.push_back(8'hA5); divq.push_back(4);
      tick(50);
      analyse("a5");
      rd_chk("status_after", 16'd1, 16'h0004);

      // Back-to-back fill to full, stall, and drain in order
      wr(16'd2, 16'd2);
      acks0 = n_acks;
      wb_req(1'b1, 16'd0, 16'h0000, rd, st);
      txq.delete();
      sum_st = st;
      for (int i = 1; i < 9; i++) begin
         wb_req(1'b1, 16'd0, 16'(i), rd, st);
         sum_st += st;
      end
      check("fill_no_stall", sum_st, 32'd0);
      wb_req(1'b1, 16'd0, 16'h0009, rd, st);
      wb_idle();
      check("full_stall", st, 32'd13);
      check("burst_acks", n_acks - acks0, 32'd10);
      for (int i = 0; i < 10; i++) begin expq.push_back(8'(i)); divq.push_back(2); end
      tick(200);
      analyse("burst");

      // Divisor change during a frame applies to the next frame
      wr(16'd2, 16'd3);
      wr(16'd0, 16'h003C);
      txq.delete();
      wr(16'd0, 16'h00C3);
      wr(16'd2, 16'd8);
      wb_idle();
      expq.push_back(8'h3C); divq.push_back(3);
      expq.push_back(8'hC3); divq.push_back(8);
      tick(125);
      analyse("divchg");

      // Divisor 0 behaves as 1
      wr(16'd2, 16'd0);
      wr(16'd0, 16'h0055);
      txq.delete(); wb_idle();
      expq.push_back(8'h55); divq.push_back(1);
      tick(20);
      analyse("div0");

      // Reset mid-DATA with bytes queued
      wr(16'd2, 16'd4);
      wr(16'd0, 16'h00AA);
      wr(16'd0, 16'h00BB);
      wr(16'd0, 16'h00CC);
      wr(16'd0, 16'h00DD);
      wb_idle();
      tick(5);
      rd_chk("status_busy", 16'd1, 16'h0019);
      wb.rst = 1'b1; wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 16'd1;
      tick(1);
      check("rst_mid_ack", {31'd0, wb.ack}, 32'd0);
      check("rst_mid_txd", {31'd0, txd}, 32'd1);
      wb.rst = 1'b0; wb_idle();
      tick(1);
      rd_chk("status_post_rst", 16'd1, 16'h0004);
      rd_chk("div_post_rst", 16'd2, 16'd434);
      txq.delete();
      tick(100);
      zeros = 0;
      foreach (txq[i]) if (txq[i] !== 1'b1) zeros++;
      check("no_start_post_rst", zeros, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
